// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic [31:0] abs_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring steps on magnitudes,
// then one sign-fix cycle; divide-by-zero and signed overflow finish in one cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply or divide step per cycle, counter 31 down to 0
// FIX   | sign correction, result and rd_out committed
// DONE  | done pulse, result valid
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [4:0]  rd_pend;
    logic [31:0] b_mag;
    logic [63:0] acc;
    logic [31:0] rem_q;
    logic        neg_res;
    logic        neg_rem;

    logic        a_signed, b_signed, sa, sb;
    logic [31:0] a_abs, b_abs;
    logic        div_zero, div_ovf;
    logic [31:0] special_val;

    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa       = a_signed & op_a[31];
        sb       = b_signed & op_b[31];
        a_abs    = abs_if(sa, op_a);
        b_abs    = abs_if(sb, op_b);
        div_zero = funct3[2] && (op_b == 32'd0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (op_a == INT_MIN) && (op_b == ALL_ONES);
        if (div_zero)
            special_val = funct3[1] ? op_a : ALL_ONES;
        else
            special_val = funct3[1] ? 32'd0 : INT_MIN;
    end

    // Multiply: multiplier sits in acc[31:0] and is shifted out as the product fills in.
    logic [32:0] mul_sum;
    logic [63:0] acc_mul_next;
    // Divide: quotient bits shift into acc[31:0] as dividend bits shift out of its top.
    logic [32:0] part;
    logic        fits;
    logic [31:0] rem_next;
    logic [63:0] acc_div_next;

    always_comb begin
        mul_sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
        acc_mul_next = {mul_sum, acc[31:1]};
        part         = {rem_q, acc[31]};
        fits         = (part >= {1'b0, b_mag});
        rem_next     = fits ? 32'(part - {1'b0, b_mag}) : part[31:0];
        acc_div_next = {acc[63:32], acc[30:0], fits};
    end

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, fix_val;

    always_comb begin
        prod_fix = neg_res ? (~acc + 64'd1) : acc;
        quo_fix  = abs_if(neg_res, acc[31:0]);
        rem_fix  = abs_if(neg_rem, rem_q);
        if (!op_q[2])
            fix_val = (op_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        else
            fix_val = op_q[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= 5'd0;
            op_q    <= 3'd0;
            rd_pend <= 5'd0;
            rd_out  <= 5'd0;
            b_mag   <= 32'd0;
            acc     <= 64'd0;
            rem_q   <= 32'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        rd_pend <= rd_in;
                        b_mag   <= b_abs;
                        acc     <= {32'd0, a_abs};
                        rem_q   <= 32'd0;
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        cnt     <= 5'd31;
                        if (div_zero || div_ovf) begin
                            result <= special_val;
                            rd_out <= rd_in;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        state <= ST_IDLE;
                        cnt   <= 5'd0;
                    end else begin
                        if (op_q[2]) begin
                            acc   <= acc_div_next;
                            rem_q <= rem_next;
                        end else begin
                            acc   <= acc_mul_next;
                        end
                        if (cnt == 5'd0)
                            state <= ST_FIX;
                        else
                            cnt <= cnt - 5'd1;
                    end
                end
                ST_FIX: begin
                    if (kill) begin
                        state <= ST_IDLE;
                    end else begin
                        result <= fix_val;
                        rd_out <= rd_pend;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign we_out = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, control and reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        kill = 1'b0;
    logic        busy, done, we_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .kill(kill),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or the bound expires); n counts cycles after accept.
    task automatic wait_done(output int n, output logic busy_ok);
        n = 1;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int n;
        logic bok;
        issue(f, a, b, rd);
        wait_done(n, bok);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_result"}, result, exp);
        chk({tag, "_rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        chk({tag, "_we_out"}, {31'd0, we_out}, {31'd0, (rd != 5'd0)});
        chk({tag, "_busy"}, {31'd0, bok}, 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        logic bok;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        chk("rst_we_out", {31'd0, we_out}, 32'd0);
        resetn = 1'b1;

        run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);
        run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 34);
        run_op("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 34);
        run_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 34);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 34);
        run_op("divu_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'h7FFF_FFFC, 34);
        run_op("remu_m7_2", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'h0000_0001, 34);
        run_op("div_9_0", 3'b100, 32'd9, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
        run_op("rd_zero", 3'b000, 32'd3, 32'd3, 5'd0, 32'd9, 34);

        // start while busy must be ignored and must not queue
        issue(3'b000, 32'd6, 32'd7, 5'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bok);
        chk("busy_start_latency", 32'(n + 5), 32'd34);
        chk("busy_start_result", result, 32'd42);
        chk("busy_start_rd_out", {27'd0, rd_out}, 32'd3);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("busy_start_no_queue", 32'(seen), 32'd0);

        // kill in the 10th cycle of CALC
        issue(3'b001, 32'd100, 32'd200, 5'd7);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("kill_no_done", 32'(seen), 32'd0);
        chk("kill_result_kept", result, 32'd42);
        chk("kill_rd_kept", {27'd0, rd_out}, 32'd3);

        // asynchronous reset in the 12th cycle of CALC
        issue(3'b000, 32'd9, 32'd9, 5'd4);
        repeat (11) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("post_rst_mul", 3'b000, 32'd3, 32'd4, 5'd6, 32'd12, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
